// File: rtl/cmos_ctrl_pkg.sv
// Shared types and constants for the CMOS break-before-make gate controller.
package cmos_ctrl_pkg;

  localparam int DEAD_W_DEF = 8;
  localparam int SW_CNT_W   = 16;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/deadtime_counter.sv
// Dead-time down-counter: loads max(cfg, 1), decrements to zero, flags the last dead cycle.
module deadtime_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_cfg,
  output logic         o_expire
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;
  logic [W-1:0] w_load_val;

  // A zero configuration would never expire, so it is clamped to one cycle.
  assign w_load_val = (i_cfg == '0) ? ONE : i_cfg;
  assign o_expire   = (r_count == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

endmodule

// File: rtl/cmos_deadtime_ctrl.sv
// Break-before-make PMOS/NMOS gate controller with programmable dead time.
// Optional switch counter output sw_count enabled by defining CMOS_DEADTIME_SWCNT_EN.
module cmos_deadtime_ctrl
  import cmos_ctrl_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_req,
  input  logic [DEAD_W-1:0] dead_cfg,
  output logic              p_gate_n,
  output logic              n_gate,
  output logic              busy,
  output logic              hiz
`ifdef CMOS_DEADTIME_SWCNT_EN
  ,
  output logic [SW_CNT_W-1:0] sw_count
`endif
);

  state_t r_state;
  logic   r_tgt;
  logic   r_p_gate_n;
  logic   r_n_gate;
  logic   r_busy;
  logic   r_hiz;
  logic   w_load;
  logic   w_dec;
  logic   w_expire;

  // Reload on every entry into DEAD; an en drop always wins over a level change.
  assign w_load = en && ((r_state == OFF) ||
                         ((r_state == HIGH) && !in_req) ||
                         ((r_state == LOW)  &&  in_req));
  assign w_dec  = en && (r_state == DEAD);

  deadtime_counter #(.W(DEAD_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_dec    (w_dec),
    .i_cfg    (dead_cfg),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OFF;
      r_tgt      <= 1'b0;
      r_p_gate_n <= 1'b1;
      r_n_gate   <= 1'b0;
      r_busy     <= 1'b0;
      r_hiz      <= 1'b1;
    end else begin
      case (r_state)
        OFF: begin
          if (en) begin
            r_state <= DEAD;
            r_tgt   <= in_req;
            r_busy  <= 1'b1;
          end
        end
        DEAD: begin
          if (!en) begin
            r_state <= OFF;
            r_busy  <= 1'b0;
          end else begin
            r_tgt <= in_req;
            if (w_expire) begin
              r_busy <= 1'b0;
              r_hiz  <= 1'b0;
              if (r_tgt) begin
                r_state    <= HIGH;
                r_p_gate_n <= 1'b0;
              end else begin
                r_state  <= LOW;
                r_n_gate <= 1'b1;
              end
            end
          end
        end
        HIGH: begin
          if (!en) begin
            r_state    <= OFF;
            r_p_gate_n <= 1'b1;
            r_hiz      <= 1'b1;
          end else if (!in_req) begin
            r_state    <= DEAD;
            r_tgt      <= 1'b0;
            r_p_gate_n <= 1'b1;
            r_busy     <= 1'b1;
            r_hiz      <= 1'b1;
          end
        end
        LOW: begin
          if (!en) begin
            r_state  <= OFF;
            r_n_gate <= 1'b0;
            r_hiz    <= 1'b1;
          end else if (in_req) begin
            r_state  <= DEAD;
            r_tgt    <= 1'b1;
            r_n_gate <= 1'b0;
            r_busy   <= 1'b1;
            r_hiz    <= 1'b1;
          end
        end
        default: begin
          r_state    <= OFF;
          r_p_gate_n <= 1'b1;
          r_n_gate   <= 1'b0;
          r_busy     <= 1'b0;
          r_hiz      <= 1'b1;
        end
      endcase
    end
  end

  assign p_gate_n = r_p_gate_n;
  assign n_gate   = r_n_gate;
  assign busy     = r_busy;
  assign hiz      = r_hiz;

`ifdef CMOS_DEADTIME_SWCNT_EN
  logic [SW_CNT_W-1:0] r_sw_count;

  // Counts device turn-ons, which only happen when DEAD expires; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_count <= '0;
    end else if ((r_state == DEAD) && en && w_expire && (r_sw_count != '1)) begin
      r_sw_count <= r_sw_count + {{(SW_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign sw_count = r_sw_count;
`endif

endmodule

// File: tb/tb_cmos_deadtime_ctrl.sv
// Directed vector bench for cmos_deadtime_ctrl, with an always-on gate overlap monitor.
module tb_cmos_deadtime_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       in_req = 1'b0;
  logic [7:0] dead_cfg = 8'd0;
  logic       p_gate_n, n_gate, busy, hiz;
`ifdef CMOS_DEADTIME_SWCNT_EN
  logic [15:0] sw_count;
`endif

  int n_checks = 0;
  int n_pass = 0;

  // {p_gate_n, n_gate, busy, hiz}
  localparam logic [3:0] S_OFF  = 4'b1001;
  localparam logic [3:0] S_DEAD = 4'b1011;
  localparam logic [3:0] S_HIGH = 4'b0000;
  localparam logic [3:0] S_LOW  = 4'b1100;

  typedef struct {
    logic       en;
    logic       in_req;
    logic [7:0] cfg;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[26];

  cmos_deadtime_ctrl #(.DEAD_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_req   (in_req),
    .dead_cfg (dead_cfg),
    .p_gate_n (p_gate_n),
    .n_gate   (n_gate),
    .busy     (busy),
    .hiz      (hiz)
`ifdef CMOS_DEADTIME_SWCNT_EN
    ,
    .sw_count (sw_count)
`endif
  );

  always #5 clk = ~clk;

  // Pull-up and pull-down must never be on together.
  always @(negedge clk) begin
    n_checks++;
    if (!p_gate_n && n_gate)
      $display("FAIL overlap at %0t: p_gate_n=%b n_gate=%b required not both on", $time, p_gate_n, n_gate);
    else
      n_pass++;
  end

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {p_gate_n, n_gate, busy, hiz};
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("%s: en=%b in_req=%b cfg=%0d pnbh=%b ok", name, en, in_req, dead_cfg, got);
    end else begin
      $display("FAIL %s: pnbh=%b required %b", name, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic r, input logic [7:0] c);
    @(negedge clk);
    en = e;
    in_req = r;
    dead_cfg = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'd3, S_OFF};
    vecs[1]  = '{1'b1, 1'b1, 8'd3, S_DEAD};
    vecs[2]  = '{1'b1, 1'b1, 8'd3, S_DEAD};
    vecs[3]  = '{1'b1, 1'b1, 8'd3, S_DEAD};
    vecs[4]  = '{1'b1, 1'b1, 8'd3, S_HIGH};
    vecs[5]  = '{1'b1, 1'b1, 8'd3, S_HIGH};
    vecs[6]  = '{1'b1, 1'b0, 8'd2, S_DEAD};
    vecs[7]  = '{1'b1, 1'b0, 8'd2, S_DEAD};
    vecs[8]  = '{1'b1, 1'b0, 8'd2, S_LOW};
    vecs[9]  = '{1'b1, 1'b0, 8'd0, S_LOW};
    vecs[10] = '{1'b1, 1'b1, 8'd0, S_DEAD};
    vecs[11] = '{1'b1, 1'b1, 8'd0, S_HIGH};
    vecs[12] = '{1'b1, 1'b0, 8'd4, S_DEAD};
    vecs[13] = '{1'b1, 1'b1, 8'd4, S_DEAD};
    vecs[14] = '{1'b1, 1'b1, 8'd9, S_DEAD};
    vecs[15] = '{1'b1, 1'b1, 8'd9, S_DEAD};
    vecs[16] = '{1'b1, 1'b1, 8'd9, S_HIGH};
    vecs[17] = '{1'b1, 1'b0, 8'd2, S_DEAD};
    vecs[18] = '{1'b0, 1'b0, 8'd2, S_OFF};
    vecs[19] = '{1'b0, 1'b1, 8'd2, S_OFF};
    vecs[20] = '{1'b1, 1'b0, 8'd1, S_DEAD};
    vecs[21] = '{1'b1, 1'b0, 8'd1, S_LOW};
    vecs[22] = '{1'b0, 1'b1, 8'd1, S_OFF};
    vecs[23] = '{1'b1, 1'b1, 8'd1, S_DEAD};
    vecs[24] = '{1'b1, 1'b1, 8'd1, S_HIGH};
    vecs[25] = '{1'b0, 1'b0, 8'd1, S_OFF};

    #1 rst_n = 1'b0;
    #3 check("reset_state", S_OFF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].en, vecs[i].in_req, vecs[i].cfg);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset while driving high: outputs drop between clock edges.
    step(1'b1, 1'b1, 8'd1);
    check("pre_rst_dead", S_DEAD);
    step(1'b1, 1'b1, 8'd1);
    check("pre_rst_high", S_HIGH);
    #2 rst_n = 1'b0;
    #1 check("async_reset", S_OFF);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'd2);
    check("post_rst_off0", S_OFF);
    step(1'b0, 1'b1, 8'd2);
    check("post_rst_off1", S_OFF);
    step(1'b1, 1'b1, 8'd2);
    check("post_rst_dead0", S_DEAD);
    step(1'b1, 1'b1, 8'd2);
    check("post_rst_dead1", S_DEAD);
    step(1'b1, 1'b1, 8'd2);
    check("post_rst_high", S_HIGH);

`ifdef CMOS_DEADTIME_SWCNT_EN
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k[0] ? 1'b1 : 1'b0, 8'd1);
      step(1'b1, k[0] ? 1'b1 : 1'b0, 8'd1);
    end
    n_checks++;
    if (sw_count === 16'd5) n_pass++;
    else $display("FAIL sw_count_5: got %0d required 5", sw_count);
    $display("sw_count after 5 turn-ons = %0d", sw_count);
    force dut.r_sw_count = 16'hFFFE;
    #1 release dut.r_sw_count;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, k[0] ? 1'b1 : 1'b0, 8'd1);
      step(1'b1, k[0] ? 1'b1 : 1'b0, 8'd1);
    end
    n_checks++;
    if (sw_count === 16'hFFFF) n_pass++;
    else $display("FAIL sw_count_sat: got %h required ffff", sw_count);
    $display("sw_count after saturation run = %h", sw_count);
`endif

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
